// File: rtl/md_unit_param_if.sv
// rtl/md_unit_param_if.sv - E-stage multiply/divide request and HI/LO result bundle
interface md_unit_param_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       md_op;
  logic             cancel;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, md_op, cancel, a, b, input busy, hi, lo);
  modport slave  (input start, md_op, cancel, a, b, output busy, hi, lo);
endinterface

// File: rtl/md_unit_param.sv
// rtl/md_unit_param.sv - parametrised multi-cycle multiply/divide unit with HI/LO registers
module md_unit_param #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic          i_clk,
  input  logic          i_reset,
  md_unit_param_if.slave s_md
);
  localparam int LAT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0]   r_pend_hi, r_pend_lo, r_hi, r_lo, w_hi_nxt, w_lo_nxt;
  logic               r_pend_we, r_busy, w_busy_nxt;
  logic               w_accept, w_is_mul, w_is_div, w_launch;

  logic [2*WIDTH-1:0] w_a_ext, w_b_ext, w_prod;
  logic               w_sdiv, w_a_neg, w_b_neg, w_b_zero;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_q_mag, w_r_mag, w_quot, w_rem;

  assign w_accept = s_md.start & ~s_md.cancel & ~r_busy & (s_md.md_op <= 3'd5);
  assign w_is_mul = (s_md.md_op[2:1] == 2'b00);
  assign w_is_div = (s_md.md_op[2:1] == 2'b01);
  assign w_launch = w_accept & (w_is_mul | w_is_div);

  // Sign-extend for mult, zero-extend for multu; the low 2*WIDTH bits of the product are exact either way.
  assign w_a_ext = (s_md.md_op == 3'd0 && s_md.a[WIDTH-1]) ? {{WIDTH{1'b1}}, s_md.a} : {{WIDTH{1'b0}}, s_md.a};
  assign w_b_ext = (s_md.md_op == 3'd0 && s_md.b[WIDTH-1]) ? {{WIDTH{1'b1}}, s_md.b} : {{WIDTH{1'b0}}, s_md.b};
  assign w_prod  = w_a_ext * w_b_ext;

  // Signed divide via magnitudes: MIN_INT / -1 naturally wraps to MIN_INT with remainder 0.
  assign w_sdiv   = (s_md.md_op == 3'd2);
  assign w_a_neg  = w_sdiv & s_md.a[WIDTH-1];
  assign w_b_neg  = w_sdiv & s_md.b[WIDTH-1];
  assign w_b_zero = (s_md.b == '0);
  assign w_a_mag  = w_a_neg ? (~s_md.a + 1'b1) : s_md.a;
  assign w_b_mag  = w_b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : (w_b_neg ? (~s_md.b + 1'b1) : s_md.b);
  assign w_q_mag  = w_a_mag / w_b_mag;
  assign w_r_mag  = w_a_mag % w_b_mag;
  assign w_quot   = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 1'b1) : w_q_mag;
  assign w_rem    = w_a_neg ? (~w_r_mag + 1'b1) : w_r_mag;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_we <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_busy  <= w_busy_nxt;
      if (w_launch) begin
        r_pend_hi <= w_is_mul ? w_prod[2*WIDTH-1:WIDTH] : w_rem;
        r_pend_lo <= w_is_mul ? w_prod[WIDTH-1:0] : w_quot;
        r_pend_we <= w_is_mul | ~w_b_zero;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_launch) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = w_is_mul ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
        end
      end
      S_RUN: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_hi_nxt   = r_hi;
    w_lo_nxt   = r_lo;
    w_busy_nxt = (w_state_nxt == S_RUN);
    if (r_state == S_RUN && r_cnt == '0 && r_pend_we) begin
      w_hi_nxt = r_pend_hi;
      w_lo_nxt = r_pend_lo;
    end
    if (r_state == S_IDLE && w_accept && s_md.md_op == 3'd4) w_hi_nxt = s_md.a;
    if (r_state == S_IDLE && w_accept && s_md.md_op == 3'd5) w_lo_nxt = s_md.a;
  end

  assign s_md.busy = r_busy;
  assign s_md.hi   = r_hi;
  assign s_md.lo   = r_lo;
endmodule
